// File: rtl/bram_sdp_init.sv
// bram_sdp_init: simple-dual-port block RAM with byte-enable writes, a registered read
// pipeline of configurable depth, and a self-clear sweep that zeroes every word after reset.
//
// Build option: define BRAM_SDP_WRITE_FIRST_EN to make a same-address read/write collision
// return the freshly merged word (write-first). Left undefined, a collision returns the
// old contents (read-first). No other behaviour changes.
//
// Parameters:
//   ADDR_WIDTH  address width
//   DATA_WIDTH  word width, multiple of 8
//   DEPTH       number of words, DEPTH <= 2**ADDR_WIDTH
//   RD_LATENCY  cycles from an accepted read to rd_valid, 1..3
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   re         read request
//   rd_addr    read address
//   rd_data    registered read data, holds its last valid value
//   rd_valid   one-cycle strobe per accepted read
//   we         write request
//   wr_addr    write address
//   wr_data    write data
//   wr_be      byte enables, bit i covers wr_data[8i+7:8i]
//   init_done  high once the clear sweep has finished

module bram_sdp_init #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 192,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    init_done
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    localparam logic [0:0] StInit  = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StInit: begin
                if (cnt_q == LastAddr) begin
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StReady;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic ready;
    assign ready     = (state_q == StReady);
    assign init_done = ready;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic rd_acc;
    logic rd_in_range;
    logic wr_acc;
    logic collision;

    assign rd_in_range = ({1'b0, rd_addr} < DepthExt);
    assign rd_acc      = re && ready;
    assign wr_acc      = we && ready && ({1'b0, wr_addr} < DepthExt);
    assign collision   = rd_acc && wr_acc && (rd_addr == wr_addr);

    // ------------------------------------------------------------------
    // Storage. The sweep shares the single write port with user writes;
    // user writes cannot occur while the sweep runs.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NumBytes-1:0]   mem_be;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_be    = wr_be;
        if (!ready) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (wr_acc && (wr_be != '0)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(NumBytes); i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word selection. The array read sees contents before this
    // edge's write, which is the read-first result by construction.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
        end
`ifdef BRAM_SDP_WRITE_FIRST_EN
        if (collision) begin
            for (int i = 0; i < int'(NumBytes); i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
`else
        // Read-first: the old word is returned; the write lands this edge anyway.
        if (collision) begin
            rd_word = mem[rd_addr];
        end
`endif
    end

    // ------------------------------------------------------------------
    // Read pipeline. Data in a stage only advances alongside a valid bit,
    // so the last stage naturally holds the most recent valid word.
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rd_valid = vld_q[RD_LATENCY-1];
    assign rd_data  = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_bram_sdp_init.sv
// Bench for bram_sdp_init (DEPTH=12, ADDR_WIDTH=4, RD_LATENCY=3). A word-level model of the
// memory plus a table of expected strobes keyed by edge number predicts every output.
module tb_bram_sdp_init;

    localparam int AW = 4;
    localparam int DW = 192;
    localparam int NB = DW / 8;
    localparam int D  = 12;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          re = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          we = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NB-1:0] wr_be = '0;
    logic          init_done;

    bram_sdp_init #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (D),
        .RD_LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .re        (re),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mdl [D];
    bit            in_rst;
    int            since_rel;
    bit            exp_init;
    bit            exp_vld;
    logic [DW-1:0] exp_dat;
    int            ecnt;
    bit            pend_v [int];
    logic [DW-1:0] pend_d [int];

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = b;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    // Drive one cycle's inputs, advance one edge, update the model, check at the negedge.
    task automatic cyc(input bit r, input logic [AW-1:0] ra, input bit w,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] be);
        bit            rd_ok;
        bit            wr_ok;
        logic [DW-1:0] rv;
        re = r; rd_addr = ra; we = w; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_ok = !in_rst && exp_init && r;
        wr_ok = !in_rst && exp_init && w && (wa < D);
        rv = '0;
        if (rd_ok && ra < D) rv = mdl[ra];
`ifdef BRAM_SDP_WRITE_FIRST_EN
        if (rd_ok && wr_ok && wa == ra) rv = merge(mdl[wa], wd, be);
`endif
        @(posedge clk);
        ecnt++;
        if (!in_rst) begin
            if (rd_ok) begin
                pend_v[ecnt + L - 1] = 1'b1;
                pend_d[ecnt + L - 1] = rv;
            end
            if (wr_ok) mdl[wa] = merge(mdl[wa], wd, be);
            since_rel++;
            if (!exp_init && since_rel == D) begin
                exp_init = 1'b1;
                for (int i = 0; i < D; i++) mdl[i] = '0;
            end
            if (pend_v.exists(ecnt)) begin
                exp_vld = 1'b1;
                exp_dat = pend_d[ecnt];
                pend_v.delete(ecnt);
                pend_d.delete(ecnt);
            end else begin
                exp_vld = 1'b0;
            end
        end
        @(negedge clk);
        chk("rd_valid", DW'(rd_valid), DW'(exp_vld));
        chk("rd_data", rd_data, exp_dat);
        chk("init_done", DW'(init_done), DW'(exp_init));
    endtask

    task automatic rnd_cyc();
        logic [DW-1:0] wd;
        logic [31:0]   be32;
        for (int i = 0; i < DW / 32; i++) wd[32*i +: 32] = $urandom;
        be32 = $urandom;
        cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 15)), wd, be32[NB-1:0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) cyc(1'b1, AW'(a), 1'b0, '0, '0, '0);
        idle(L);
    endtask

    // Called at a negedge: assert reset, check the asynchronous clear, release at a negedge.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        in_rst = 1'b1;
        pend_v.delete();
        pend_d.delete();
        exp_vld = 1'b0;
        exp_dat = '0;
        exp_init = 1'b0;
        #1;
        chk("rst_valid", DW'(rd_valid), '0);
        chk("rst_data", rd_data, '0);
        chk("rst_init", DW'(init_done), '0);
        for (int i = 0; i < hold; i++) rnd_cyc();
        rst_n = 1'b1;
        in_rst = 1'b0;
        since_rel = 0;
    endtask

    initial begin
        ecnt = 0;
        since_rel = 0;
        exp_init = 1'b0;
        exp_vld = 1'b0;
        exp_dat = '0;
        in_rst = 1'b0;
        for (int i = 0; i < D; i++) mdl[i] = '0;

        @(negedge clk);
        do_reset(2);

        // Sweep with random traffic that must be ignored; init_done checked every cycle.
        for (int i = 0; i < D; i++) rnd_cyc();
        read_all();

        // Byte-enable merge
        cyc(1'b0, '0, 1'b1, 4'd5, fill(8'hAA), '1);
        cyc(1'b0, '0, 1'b1, 4'd5, fill(8'h55), 24'h00000F);
        cyc(1'b1, 4'd5, 1'b0, '0, '0, '0);
        idle(L);
        chk("be_merge", rd_data, {{20{8'hAA}}, {4{8'h55}}});

        // Latency and back-to-back throughput
        for (int k = 1; k <= 3; k++) cyc(1'b0, '0, 1'b1, AW'(k), DW'(k), '1);
        cyc(1'b1, 4'd1, 1'b0, '0, '0, '0);
        chk("lat_early0", DW'(rd_valid), '0);
        cyc(1'b1, 4'd2, 1'b0, '0, '0, '0);
        chk("lat_early1", DW'(rd_valid), '0);
        cyc(1'b1, 4'd3, 1'b0, '0, '0, '0);
        chk("lat_v1", DW'(rd_valid), DW'(1));
        chk("lat_d1", rd_data, DW'(1));
        idle(1);
        chk("lat_d2", rd_data, DW'(2));
        idle(1);
        chk("lat_d3", rd_data, DW'(3));
        idle(1);
        chk("lat_end", DW'(rd_valid), '0);

        // Collision
        cyc(1'b0, '0, 1'b1, 4'd7, fill(8'h11), '1);
        cyc(1'b1, 4'd7, 1'b1, 4'd7, fill(8'h22), '1);
        idle(L - 1);
`ifdef BRAM_SDP_WRITE_FIRST_EN
        chk("collide", rd_data, fill(8'h22));
`else
        chk("collide", rd_data, fill(8'h11));
`endif
        cyc(1'b1, 4'd7, 1'b0, '0, '0, '0);
        idle(L);
        chk("after_collide", rd_data, fill(8'h22));

        // Out-of-range write and read
        cyc(1'b0, '0, 1'b1, 4'd13, fill(8'hEE), '1);
        cyc(1'b1, 4'd13, 1'b0, '0, '0, '0);
        idle(L - 1);
        chk("oor_valid", DW'(rd_valid), DW'(1));
        chk("oor_data", rd_data, '0);
        read_all();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) rnd_cyc();
        idle(L);

        // Reset with a read in flight, then sweep must clear the random contents
        cyc(1'b1, 4'd4, 1'b0, '0, '0, '0);
        do_reset(2);
        for (int i = 0; i < D; i++) rnd_cyc();
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
